lamp_conflict_monitor: RTL and testbench

- Sits directly downstream of the traffic-light controller: consumes its 3-bit RGY lamp vector every clock and drives the physical lamp outputs.
- Checks every sample for an illegal lamp pattern, an out-of-order transition and a dwell-time violation.
- On the first fault it latches a fault code and forces the lamps to flashing red (safe mode) until cleared.
- Also counts completed red→green→yellow→red cycles for maintenance telemetry.

---
 rtl/lamp_pkg.sv | 38 +++
 rtl/lamp_conflict_monitor_flash_gen.sv | 46 ++++
 rtl/lamp_conflict_monitor.sv | 148 ++++++++++++++
 tb/tb_lamp_conflict_monitor.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/lamp_pkg.sv
// Shared lamp encodings, fault codes, monitor state encoding and the legal
// lamp-sequence helpers for the lamp conflict monitor.
package lamp_pkg;

    typedef logic [0:2] lamp_t;

    localparam lamp_t LAMP_R   = 3'b100;
    localparam lamp_t LAMP_G   = 3'b010;
    localparam lamp_t LAMP_Y   = 3'b001;
    localparam lamp_t LAMP_OFF = 3'b000;

    localparam logic [2:0] FLT_NONE    = 3'd0;
    localparam logic [2:0] FLT_PATTERN = 3'd1;
    localparam logic [2:0] FLT_ORDER   = 3'd2;
    localparam logic [2:0] FLT_SHORT   = 3'd3;
    localparam logic [2:0] FLT_LONG    = 3'd4;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    // Successor in the R->G->Y->R sequence; anything illegal maps to OFF.
    function automatic lamp_t next_legal(input lamp_t lamp);
        lamp_t nxt;
        case (lamp)
            LAMP_R:  nxt = LAMP_G;
            LAMP_G:  nxt = LAMP_Y;
            LAMP_Y:  nxt = LAMP_R;
            default: nxt = LAMP_OFF;
        endcase
        return nxt;
    endfunction

    function automatic logic is_legal(input lamp_t lamp);
        return (lamp == LAMP_R) || (lamp == LAMP_G) || (lamp == LAMP_Y);
    endfunction

endpackage

// File: rtl/lamp_conflict_monitor_flash_gen.sv
// Safe-mode flash phase generator: FLASH_HALF cycles on, FLASH_HALF cycles
// off, held at the start of the on phase while restart is asserted.
module flash_gen #(
    parameter int FLASH_HALF = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic on_next
);

    localparam int CW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          on_q, on_d;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        on_d  = on_q;
        if (restart) begin
            cnt_d = '0;
            on_d  = 1'b1;
        end else if (cnt_q == CW'(FLASH_HALF - 1)) begin
            cnt_d = '0;
            on_d  = ~on_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The next phase is exported so the caller can register the lamp in step with it.
    assign on_next = on_d;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            on_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            on_q  <= on_d;
        end
    end

endmodule

// File: rtl/lamp_conflict_monitor.sv
// Lamp conflict monitor: passes controller lamps through one cycle late,
// latches the first pattern/order/dwell fault and flashes red until cleared.
module lamp_conflict_monitor
    import lamp_pkg::*;
#(
    parameter int MIN_DWELL  = 2,
    parameter int MAX_DWELL  = 32,
    parameter int CNT_W      = 6,
    parameter int FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:2] light_in,
    input  logic       fault_clr,
    output logic [0:2] lamp_out,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] cycle_cnt
);

    logic [1:0]       state_q, state_d;
    lamp_t            prev_q, prev_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [2:0]       code_q, code_d;
    logic [7:0]       cycle_q, cycle_d;
    lamp_t            lamp_q, lamp_d;

    logic flash_restart;
    logic flash_on_next;

    logic in_legal;
    logic in_same;
    logic in_in_order;

    assign in_legal    = is_legal(light_in);
    assign in_same     = (light_in == prev_q);
    assign in_in_order = (light_in == next_legal(prev_q));

    // Hold the flash at its on phase outside FAULT and on the clearing edge.
    assign flash_restart = (state_q != ST_FAULT) || fault_clr;

    flash_gen #(
        .FLASH_HALF(FLASH_HALF)
    ) u_flash_gen (
        .clk    (clk),
        .rst    (rst),
        .restart(flash_restart),
        .on_next(flash_on_next)
    );

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        dwell_d = dwell_q;
        code_d  = code_q;
        cycle_d = cycle_q;
        lamp_d  = lamp_q;

        case (state_q)
            ST_INIT: begin
                if (!in_legal) begin
                    state_d = ST_FAULT;
                    code_d  = FLT_PATTERN;
                    lamp_d  = LAMP_R;
                end else begin
                    state_d = ST_RUN;
                    prev_d  = light_in;
                    dwell_d = CNT_W'(1);
                    lamp_d  = light_in;
                end
            end

            ST_RUN: begin
                if (!in_legal) begin
                    code_d = FLT_PATTERN;
                end else if (!in_same && !in_in_order) begin
                    code_d = FLT_ORDER;
                end else if (!in_same && (dwell_q < CNT_W'(MIN_DWELL))) begin
                    code_d = FLT_SHORT;
                end else if (in_same && (dwell_q >= CNT_W'(MAX_DWELL))) begin
                    code_d = FLT_LONG;
                end

                if (code_d != FLT_NONE) begin
                    state_d = ST_FAULT;
                    lamp_d  = LAMP_R;
                end else begin
                    lamp_d = light_in;
                    if (in_same) begin
                        if (dwell_q != CNT_W'(MAX_DWELL + 1)) begin
                            dwell_d = dwell_q + 1'b1;
                        end
                    end else begin
                        dwell_d = CNT_W'(1);
                        prev_d  = light_in;
                        if (prev_q == LAMP_Y) begin
                            cycle_d = cycle_q + 8'd1;
                        end
                    end
                end
            end

            ST_FAULT: begin
                if (fault_clr) begin
                    state_d = ST_INIT;
                    code_d  = FLT_NONE;
                    dwell_d = '0;
                    prev_d  = LAMP_OFF;
                    lamp_d  = LAMP_R;
                end else begin
                    lamp_d = flash_on_next ? LAMP_R : LAMP_OFF;
                end
            end

            default: begin
                state_d = ST_INIT;
                code_d  = FLT_NONE;
                dwell_d = '0;
                prev_d  = LAMP_OFF;
                lamp_d  = LAMP_R;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            prev_q  <= LAMP_OFF;
            dwell_q <= '0;
            code_q  <= FLT_NONE;
            cycle_q <= '0;
            lamp_q  <= LAMP_R;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            dwell_q <= dwell_d;
            code_q  <= code_d;
            cycle_q <= cycle_d;
            lamp_q  <= lamp_d;
        end
    end

    assign lamp_out   = lamp_q;
    assign fault      = (state_q == ST_FAULT);
    assign fault_code = code_q;
    assign cycle_cnt  = cycle_q;

endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// Directed self-checking bench for lamp_conflict_monitor with default parameters.
module tb_lamp_conflict_monitor;

    localparam logic [0:2] R   = 3'b100;
    localparam logic [0:2] G   = 3'b010;
    localparam logic [0:2] Y   = 3'b001;
    localparam logic [0:2] OFF = 3'b000;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:2] light_in;
    logic       fault_clr;
    logic [0:2] lamp_out;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] cycle_cnt;

    int checks   = 0;
    int failures = 0;

    lamp_conflict_monitor dut (
        .clk       (clk),
        .rst       (rst),
        .light_in  (light_in),
        .fault_clr (fault_clr),
        .lamp_out  (lamp_out),
        .fault     (fault),
        .fault_code(fault_code),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [0:2] v, input logic clr);
        light_in  = v;
        fault_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [0:2] l, input logic f,
                              input logic [2:0] c);
        check({tag, ".lamp"}, 32'(lamp_out), 32'(l));
        check({tag, ".fault"}, 32'(fault), 32'(f));
        check({tag, ".code"}, 32'(fault_code), 32'(c));
    endtask

    logic [0:2] seq [19] = '{R, R, R, G, G, G, Y, Y, Y, R, R, R, G, G, G, Y, Y, Y, R};

    initial begin
        rst       = 1'b1;
        light_in  = R;
        fault_clr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outs("reset", R, 1'b0, 3'd0);
        check("reset.cnt", 32'(cycle_cnt), 32'd0);
        rst = 1'b0;

        // Two full legal cycles: pass-through one cycle late, two completions.
        for (int i = 0; i < 19; i++) begin
            step(seq[i], 1'b0);
            check_outs($sformatf("legal[%0d]", i), seq[i], 1'b0, 3'd0);
            if (i == 9) check("legal.cnt1", 32'(cycle_cnt), 32'd1);
        end
        check("legal.cnt2", 32'(cycle_cnt), 32'd2);

        // Multi-hot pattern: fault on the sampling edge, then free-running flash.
        step(3'b110, 1'b0);
        check_outs("illegal.entry", R, 1'b1, 3'd1);
        for (int i = 1; i <= 8; i++) begin
            step((i == 5) ? Y : 3'b110, 1'b0);
            check_outs($sformatf("flash[%0d]", i), (i >= 4 && i <= 7) ? OFF : R, 1'b1, 3'd1);
        end

        // Clear and violation on the same edge: clear wins.
        step(3'b011, 1'b1);
        check_outs("clr.vs.viol", R, 1'b0, 3'd0);
        check("clr.cnt_kept", 32'(cycle_cnt), 32'd2);

        // Out-of-order R->Y.
        step(R, 1'b0);
        check_outs("order.enter", R, 1'b0, 3'd0);
        step(R, 1'b0);
        step(Y, 1'b0);
        check_outs("order.fault", R, 1'b1, 3'd2);
        step(R, 1'b1);
        check_outs("order.clr", R, 1'b0, 3'd0);

        // Re-entry, clear ignored in RUN, then dwell too short on G.
        step(R, 1'b0);
        check_outs("reenter", R, 1'b0, 3'd0);
        step(R, 1'b1);
        check_outs("clr.in_run", R, 1'b0, 3'd0);
        step(G, 1'b0);
        check_outs("short.g1", G, 1'b0, 3'd0);
        step(Y, 1'b0);
        check_outs("short.fault", R, 1'b1, 3'd3);
        step(R, 1'b1);

        // R held exactly 32 cycles is legal; the 33rd sample faults.
        for (int i = 1; i <= 32; i++) step(R, 1'b0);
        check_outs("hold32", R, 1'b0, 3'd0);
        step(R, 1'b0);
        check_outs("hold33", R, 1'b1, 3'd4);
        step(R, 1'b1);

        // 000 after a 1-cycle G dwell: pattern fault takes priority.
        step(R, 1'b0);
        step(R, 1'b0);
        step(G, 1'b0);
        step(OFF, 1'b0);
        check_outs("prio", R, 1'b1, 3'd1);
        step(3'b111, 1'b0);
        check_outs("second.viol", R, 1'b1, 3'd1);

        // Asynchronous reset in the middle of a FAULT clock cycle.
        #2;
        rst = 1'b1;
        #1;
        check_outs("async.rst", R, 1'b0, 3'd0);
        check("async.rst.cnt", 32'(cycle_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(G, 1'b0);
        check_outs("post.rst", G, 1'b0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
